// File: rtl/logic_gate_unit.sv
// logic_gate_unit
// Registered bitwise logic unit with a valid/ready request path and a
// truth-table sweep engine. The datapath applies one of eight two-input
// functions to every bit of a and b independently; the sweep engine
// evaluates the selected function over all four input combinations and
// captures the result in a 4-bit truth table.

module logic_gate_unit #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   input  logic             sweep_start,
   output logic             sweep_busy,
   output logic [3:0]       truth,
   output logic             truth_valid
);

   // Sweep sequencer states: wait, evaluate one table row per cycle, announce.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      STEP = 2'd1,
      DONE = 2'd2
   } state_t;

   // Function encoding shared by the datapath and the sweep engine.
   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_NAND = 3'b010;
   localparam logic [2:0] OP_NOR  = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_XNOR = 3'b101;
   localparam logic [2:0] OP_AONB = 3'b110;
   localparam logic [2:0] OP_NAOB = 3'b111;

   // ------------------------------------------------------------------
   // Function helpers
   // ------------------------------------------------------------------

   // Bitwise evaluation over the full operand width; every bit position
   // is computed from the same bit index of x and y only.
   function automatic logic [WIDTH-1:0] gate_vec(
      input logic [2:0]       sel,
      input logic [WIDTH-1:0] x,
      input logic [WIDTH-1:0] y
   );
      case (sel)
         OP_AND:  gate_vec = x & y;
         OP_OR:   gate_vec = x | y;
         OP_NAND: gate_vec = ~(x & y);
         OP_NOR:  gate_vec = ~(x | y);
         OP_XOR:  gate_vec = x ^ y;
         OP_XNOR: gate_vec = ~(x ^ y);
         OP_AONB: gate_vec = x | ~y;
         OP_NAOB: gate_vec = ~x | y;
         default: gate_vec = {WIDTH{1'b0}};
      endcase
   endfunction

   // Single-bit evaluation used to build one truth-table row.
   function automatic logic gate_bit(
      input logic [2:0] sel,
      input logic       x,
      input logic       y
   );
      case (sel)
         OP_AND:  gate_bit = x & y;
         OP_OR:   gate_bit = x | y;
         OP_NAND: gate_bit = ~(x & y);
         OP_NOR:  gate_bit = ~(x | y);
         OP_XOR:  gate_bit = x ^ y;
         OP_XNOR: gate_bit = ~(x ^ y);
         OP_AONB: gate_bit = x | ~y;
         OP_NAOB: gate_bit = ~x | y;
         default: gate_bit = 1'b0;
      endcase
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t           state_r;
   logic [1:0]       idx_r;
   logic [2:0]       sweep_op_r;
   logic [3:0]       truth_r;
   logic             truth_valid_r;
   logic             sweep_busy_r;
   logic [WIDTH-1:0] s_r;
   logic             out_valid_r;

   logic             in_ready_s;
   logic             accept_s;

   // ------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------

   // A request is only taken while the sequencer is idle, no sweep is being
   // requested (the sweep wins a tie) and the output slot is free or draining.
   assign in_ready_s = (state_r == IDLE) && !sweep_start && (!out_valid_r || out_ready);
   assign accept_s   = in_valid && in_ready_s;

   // ------------------------------------------------------------------
   // Datapath result register
   // ------------------------------------------------------------------

   // Load a new result on accept; otherwise hold it until the consumer
   // drains it. Accept and drain together keep out_valid high.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_r         <= {WIDTH{1'b0}};
         out_valid_r <= 1'b0;
      end else if (accept_s) begin
         s_r         <= gate_vec(op, a, b);
         out_valid_r <= 1'b1;
      end else if (out_ready) begin
         s_r         <= s_r;
         out_valid_r <= 1'b0;
      end else begin
         s_r         <= s_r;
         out_valid_r <= out_valid_r;
      end
   end

   // ------------------------------------------------------------------
   // Truth-table sweep sequencer
   // ------------------------------------------------------------------

   // Latch the function on start, fill one table row per STEP cycle using
   // the latched function, then raise truth_valid for the single DONE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= IDLE;
         idx_r         <= 2'd0;
         sweep_op_r    <= 3'b000;
         truth_r       <= 4'b0000;
         truth_valid_r <= 1'b0;
         sweep_busy_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               truth_valid_r <= 1'b0;
               if (sweep_start) begin
                  sweep_op_r   <= op;
                  idx_r        <= 2'd0;
                  sweep_busy_r <= 1'b1;
                  state_r      <= STEP;
               end else begin
                  sweep_busy_r <= 1'b0;
                  state_r      <= IDLE;
               end
            end
            STEP: begin
               truth_r[idx_r] <= gate_bit(sweep_op_r, idx_r[1], idx_r[0]);
               idx_r          <= idx_r + 2'd1;
               sweep_busy_r   <= 1'b1;
               if (idx_r == 2'd3) begin
                  truth_valid_r <= 1'b1;
                  state_r       <= DONE;
               end else begin
                  truth_valid_r <= 1'b0;
                  state_r       <= STEP;
               end
            end
            DONE: begin
               truth_valid_r <= 1'b0;
               sweep_busy_r  <= 1'b0;
               state_r       <= IDLE;
            end
            default: begin
               // Unreachable encoding: recover to a quiet idle state.
               truth_valid_r <= 1'b0;
               sweep_busy_r  <= 1'b0;
               idx_r         <= 2'd0;
               state_r       <= IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign in_ready    = in_ready_s;
   assign s           = s_r;
   assign out_valid   = out_valid_r;
   assign truth       = truth_r;
   assign truth_valid = truth_valid_r;
   assign sweep_busy  = sweep_busy_r;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed testbench for logic_gate_unit (WIDTH = 4) with hand-computed
// expected values.

module tb_logic_gate_unit;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [2:0]   op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] s;
   logic         sweep_start;
   logic         sweep_busy;
   logic [3:0]   truth;
   logic         truth_valid;

   int checks_cnt;
   int errors_cnt;

   logic [2:0] op_tab  [8];
   logic [3:0] exp_tab [8];

   logic_gate_unit #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .op          (op),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .s           (s),
      .sweep_start (sweep_start),
      .sweep_busy  (sweep_busy),
      .truth       (truth),
      .truth_valid (truth_valid)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run a sweep of function f and check busy length, the single
   // truth_valid pulse, the final table and that no result is loaded.
   task automatic run_sweep(input logic [2:0] f, input logic [3:0] exp_truth, input logic with_req);
      op          = f;
      sweep_start = 1'b1;
      in_valid    = with_req;
      a           = 4'b1111;
      b           = 4'b1111;
      out_ready   = 1'b1;
      #1;
      check("sweep_in_ready", 32'(in_ready), 32'd0);
      tick();
      sweep_start = 1'b0;
      in_valid    = 1'b0;
      op          = ~f;
      check("sweep_no_result", 32'(out_valid), 32'd0);
      for (int k = 1; k <= 5; k++) begin
         check($sformatf("sweep_busy_c%0d", k), 32'(sweep_busy), 32'd1);
         check($sformatf("sweep_tv_c%0d", k), 32'(truth_valid), (k == 5) ? 32'd1 : 32'd0);
         if (k == 5) begin
            check("sweep_truth_done", 32'(truth), 32'(exp_truth));
         end else begin
            check("sweep_in_ready_busy", 32'(in_ready), 32'd0);
         end
         tick();
      end
      check("sweep_busy_end", 32'(sweep_busy), 32'd0);
      check("sweep_tv_end", 32'(truth_valid), 32'd0);
      check("sweep_truth_hold", 32'(truth), 32'(exp_truth));
   endtask

   initial begin
      checks_cnt  = 0;
      errors_cnt  = 0;
      rst         = 1'b1;
      in_valid    = 1'b0;
      a           = 4'b0000;
      b           = 4'b0000;
      op          = 3'b000;
      out_ready   = 1'b0;
      sweep_start = 1'b0;

      // a=0011 b=0101 under every function
      op_tab[0] = 3'b000; exp_tab[0] = 4'b0001;
      op_tab[1] = 3'b001; exp_tab[1] = 4'b0111;
      op_tab[2] = 3'b010; exp_tab[2] = 4'b1110;
      op_tab[3] = 3'b011; exp_tab[3] = 4'b1000;
      op_tab[4] = 3'b100; exp_tab[4] = 4'b0110;
      op_tab[5] = 3'b101; exp_tab[5] = 4'b1001;
      op_tab[6] = 3'b110; exp_tab[6] = 4'b1011;
      op_tab[7] = 3'b111; exp_tab[7] = 4'b1101;

      // Reset state
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_s", 32'(s), 32'd0);
      check("rst_truth", 32'(truth), 32'd0);
      check("rst_truth_valid", 32'(truth_valid), 32'd0);
      check("rst_sweep_busy", 32'(sweep_busy), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Back-to-back requests with the consumer always ready
      a         = 4'b0011;
      b         = 4'b0101;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         op = op_tab[i];
         #1;
         check($sformatf("op%0d_in_ready", i), 32'(in_ready), 32'd1);
         tick();
         check($sformatf("op%0d_out_valid", i), 32'(out_valid), 32'd1);
         check($sformatf("op%0d_s", i), 32'(s), 32'(exp_tab[i]));
      end

      // Drain with no new request clears out_valid
      in_valid = 1'b0;
      tick();
      check("drain_out_valid", 32'(out_valid), 32'd0);

      // Back-pressure: result held while out_ready low
      in_valid  = 1'b1;
      a         = 4'b1100;
      b         = 4'b0011;
      op        = 3'b001;
      out_ready = 1'b0;
      tick();
      check("bp_load_valid", 32'(out_valid), 32'd1);
      check("bp_load_s", 32'(s), 32'h0F);
      a  = 4'b1010;
      b  = 4'b0110;
      op = 3'b100;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp_in_ready", 32'(in_ready), 32'd0);
         tick();
         check("bp_hold_s", 32'(s), 32'h0F);
         check("bp_hold_valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("bp_new_s", 32'(s), 32'h0C);
      check("bp_new_valid", 32'(out_valid), 32'd1);
      in_valid = 1'b0;
      tick();
      check("bp_drain", 32'(out_valid), 32'd0);

      // Truth-table sweeps
      run_sweep(3'b110, 4'b1101, 1'b0);
      run_sweep(3'b000, 4'b1000, 1'b0);
      run_sweep(3'b100, 4'b0110, 1'b0);
      // sweep and request together: sweep wins, nothing loaded
      run_sweep(3'b111, 4'b1011, 1'b1);

      // Pending result survives a sweep and drains during it
      in_valid  = 1'b1;
      a         = 4'b1100;
      b         = 4'b1010;
      op        = 3'b010;
      out_ready = 1'b0;
      tick();
      in_valid    = 1'b0;
      op          = 3'b101;
      sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      check("pend_busy", 32'(sweep_busy), 32'd1);
      check("pend_s", 32'(s), 32'h07);
      check("pend_valid", 32'(out_valid), 32'd1);
      tick();
      check("pend_hold_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      tick();
      check("pend_drained", 32'(out_valid), 32'd0);
      tick();
      tick();
      check("pend_tv", 32'(truth_valid), 32'd1);
      check("pend_truth", 32'(truth), 32'h9);
      tick();
      check("pend_idle", 32'(sweep_busy), 32'd0);

      // Reset in the second STEP cycle with a result held
      in_valid  = 1'b1;
      a         = 4'b0011;
      b         = 4'b0101;
      op        = 3'b000;
      out_ready = 1'b0;
      tick();
      in_valid    = 1'b0;
      op          = 3'b110;
      sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      tick();
      check("rs_mid_busy", 32'(sweep_busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rs_busy", 32'(sweep_busy), 32'd0);
      check("rs_truth", 32'(truth), 32'd0);
      check("rs_out_valid", 32'(out_valid), 32'd0);
      check("rs_tv", 32'(truth_valid), 32'd0);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("rs_no_tv", 32'(truth_valid), 32'd0);
         check("rs_stay_idle", 32'(sweep_busy), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
